// File: rtl/prog_run_ctrl.sv
// Run sequencer above the single-cycle core: launches each program in turn,
// times it until the core halts, and reports per-program cycle counts with a watchdog.
module prog_run_ctrl #(
    parameter int NUM_PROGS = 3,
    parameter int CW        = 16,
    parameter int START_CYC = 2,
    parameter int MAX_CYC   = 16'hFFFF,
    localparam int PW       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Abort,
    input  logic          CpuAck,
    output logic          CpuStart,
    output logic [PW-1:0] ProgSel,
    output logic          Busy,
    output logic [CW-1:0] CycleOut,
    output logic          CycleValid,
    output logic          Done,
    output logic          TimedOut
);

    localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    localparam logic [SW-1:0] START_LAST = SW'(START_CYC - 1);
    localparam logic [PW-1:0] PROG_LAST  = PW'(NUM_PROGS - 1);
    localparam logic [CW-1:0] WDOG_LAST  = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0] WDOG_VAL   = CW'(MAX_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_REPORT,
        ST_DONE
    } state_t;

    state_t        r_state;
    logic          r_cpu_start;
    logic [PW-1:0] r_prog_sel;
    logic          r_busy;
    logic [CW-1:0] r_cycle_out;
    logic          r_cycle_valid;
    logic          r_done;
    logic          r_timed_out;
    logic [CW-1:0] r_cycle_ct;
    logic [SW-1:0] r_start_ct;

    state_t        w_state_nxt;
    logic          w_cpu_start_nxt;
    logic [PW-1:0] w_prog_sel_nxt;
    logic          w_busy_nxt;
    logic [CW-1:0] w_cycle_out_nxt;
    logic          w_cycle_valid_nxt;
    logic          w_done_nxt;
    logic          w_timed_out_nxt;
    logic [CW-1:0] w_cycle_ct_nxt;
    logic [SW-1:0] w_start_ct_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_cpu_start   <= 1'b0;
            r_prog_sel    <= '0;
            r_busy        <= 1'b0;
            r_cycle_out   <= '0;
            r_cycle_valid <= 1'b0;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_cycle_ct    <= '0;
            r_start_ct    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cpu_start   <= w_cpu_start_nxt;
            r_prog_sel    <= w_prog_sel_nxt;
            r_busy        <= w_busy_nxt;
            r_cycle_out   <= w_cycle_out_nxt;
            r_cycle_valid <= w_cycle_valid_nxt;
            r_done        <= w_done_nxt;
            r_timed_out   <= w_timed_out_nxt;
            r_cycle_ct    <= w_cycle_ct_nxt;
            r_start_ct    <= w_start_ct_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt       = r_state;
        w_cpu_start_nxt   = r_cpu_start;
        w_prog_sel_nxt    = r_prog_sel;
        w_busy_nxt        = r_busy;
        w_cycle_out_nxt   = r_cycle_out;
        w_cycle_valid_nxt = 1'b0;
        w_done_nxt        = r_done;
        w_timed_out_nxt   = r_timed_out;
        w_cycle_ct_nxt    = r_cycle_ct;
        w_start_ct_nxt    = r_start_ct;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                // Abort alongside Go suppresses the launch
                if (Go && !Abort) begin
                    w_state_nxt     = ST_LAUNCH;
                    w_prog_sel_nxt  = '0;
                    w_done_nxt      = 1'b0;
                    w_timed_out_nxt = 1'b0;
                    w_start_ct_nxt  = '0;
                    w_cpu_start_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end

            ST_LAUNCH: begin
                if (Abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_cpu_start_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_prog_sel_nxt  = '0;
                end else if (r_start_ct == START_LAST) begin
                    w_state_nxt     = ST_RUN;
                    w_cpu_start_nxt = 1'b0;
                    w_cycle_ct_nxt  = '0;
                end else begin
                    w_start_ct_nxt = r_start_ct + 1'b1;
                end
            end

            ST_RUN: begin
                if (Abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_busy_nxt      = 1'b0;
                    w_prog_sel_nxt  = '0;
                end else if (CpuAck) begin
                    w_state_nxt       = ST_REPORT;
                    w_cycle_out_nxt   = r_cycle_ct;
                    w_cycle_valid_nxt = 1'b1;
                end else if (r_cycle_ct == WDOG_LAST) begin
                    // Watchdog ends the whole run; later programs are skipped
                    w_state_nxt     = ST_DONE;
                    w_cycle_out_nxt = WDOG_VAL;
                    w_timed_out_nxt = 1'b1;
                    w_done_nxt      = 1'b1;
                    w_busy_nxt      = 1'b0;
                end else begin
                    w_cycle_ct_nxt = r_cycle_ct + 1'b1;
                end
            end

            ST_REPORT: begin
                if (Abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_busy_nxt      = 1'b0;
                    w_prog_sel_nxt  = '0;
                end else if (r_prog_sel == PROG_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt     = ST_LAUNCH;
                    w_prog_sel_nxt  = r_prog_sel + 1'b1;
                    w_start_ct_nxt  = '0;
                    w_cpu_start_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_cpu_start_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    assign CpuStart   = r_cpu_start;
    assign ProgSel    = r_prog_sel;
    assign Busy       = r_busy;
    assign CycleOut   = r_cycle_out;
    assign CycleValid = r_cycle_valid;
    assign Done       = r_done;
    assign TimedOut   = r_timed_out;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: a scripted core model drives Ack on a per-program delay,
// and a timeline model of the sequencer predicts every output each cycle.
module tb_prog_run_ctrl;

    localparam int NP = 3;
    localparam int CWB = 16;
    localparam int SC = 2;
    localparam int MC = 20;
    localparam int PWB = 2;

    logic           Clk;
    logic           Reset;
    logic           Go;
    logic           Abort;
    logic           CpuAck;
    logic           CpuStart;
    logic [PWB-1:0] ProgSel;
    logic           Busy;
    logic [CWB-1:0] CycleOut;
    logic           CycleValid;
    logic           Done;
    logic           TimedOut;

    int n_checks = 0;
    int n_errors = 0;

    // Model state that persists between cycles
    int exp_cout = 0;
    int exp_ps   = 0;
    bit exp_done = 1'b0;
    bit exp_to   = 1'b0;
    int dly[NP];

    prog_run_ctrl #(
        .NUM_PROGS (NP),
        .CW        (CWB),
        .START_CYC (SC),
        .MAX_CYC   (MC)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Go         (Go),
        .Abort      (Abort),
        .CpuAck     (CpuAck),
        .CpuStart   (CpuStart),
        .ProgSel    (ProgSel),
        .Busy       (Busy),
        .CycleOut   (CycleOut),
        .CycleValid (CycleValid),
        .Done       (Done),
        .TimedOut   (TimedOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got still running, expected finished");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit cs, input int ps, input bit busy, input bit cv);
        check_eq({tag, ".CpuStart"},   32'(CpuStart),   32'(cs));
        check_eq({tag, ".ProgSel"},    32'(ProgSel),    32'(ps));
        check_eq({tag, ".Busy"},       32'(Busy),       32'(busy));
        check_eq({tag, ".CycleValid"}, 32'(CycleValid), 32'(cv));
        check_eq({tag, ".CycleOut"},   32'(CycleOut),   32'(exp_cout));
        check_eq({tag, ".Done"},       32'(Done),       32'(exp_done));
        check_eq({tag, ".TimedOut"},   32'(TimedOut),   32'(exp_to));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            Go = 1'b0;
            Abort = 1'($urandom);
            CpuAck = 1'($urandom);
            tick();
            check_all("idle", 1'b0, exp_ps, 1'b0, 1'b0);
        end
        Abort = 1'b0;
    endtask

    task automatic abort_finish();
        Abort = 1'b1;
        CpuAck = 1'($urandom);
        tick();
        Abort = 1'b0;
        Go = 1'b0;
        exp_ps = 0;
        check_all("abort", 1'b0, 0, 1'b0, 1'b0);
    endtask

    // One Go: program k is started for SC cycles, runs dly[k] Ack-low cycles, then reports.
    task automatic run_seq(input int ab_prog, input int ab_cyc, input bit noise);
        int d;
        int lim;
        Abort = 1'b0;
        CpuAck = 1'b0;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        exp_done = 1'b0;
        exp_to = 1'b0;
        for (int k = 0; k < NP; k++) begin
            d = dly[k];
            for (int s = 0; s < SC; s++) begin
                check_all("launch", 1'b1, k, 1'b1, 1'b0);
                CpuAck = 1'($urandom);
                Go = noise ? 1'($urandom) : 1'b0;
                tick();
            end
            lim = (d < MC) ? d : MC;
            for (int i = 0; i < lim; i++) begin
                check_all("run", 1'b0, k, 1'b1, 1'b0);
                Go = noise ? 1'($urandom) : 1'b0;
                if (k == ab_prog && i == ab_cyc) begin
                    abort_finish();
                    return;
                end
                CpuAck = 1'b0;
                tick();
            end
            if (d >= MC) begin
                Go = 1'b0;
                exp_cout = MC;
                exp_done = 1'b1;
                exp_to = 1'b1;
                exp_ps = k;
                check_all("timeout", 1'b0, k, 1'b0, 1'b0);
                return;
            end
            check_all("run", 1'b0, k, 1'b1, 1'b0);
            if (k == ab_prog && d == ab_cyc) begin
                abort_finish();
                return;
            end
            CpuAck = 1'b1;
            tick();
            exp_cout = d;
            check_all("report", 1'b0, k, 1'b1, 1'b1);
            CpuAck = 1'($urandom);
            Go = (noise && k < NP - 1) ? 1'($urandom) : 1'b0;
            tick();
        end
        Go = 1'b0;
        exp_done = 1'b1;
        exp_ps = NP - 1;
        check_all("done", 1'b0, NP - 1, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b0;
        Go = 1'b0;
        Abort = 1'b0;
        CpuAck = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset", 1'b0, 0, 1'b0, 1'b0);
        end
        Reset = 1'b1;
        idle_cycles(10);

        Go = 1'b1;
        Abort = 1'b1;
        tick();
        Go = 1'b0;
        Abort = 1'b0;
        check_all("abort_go_idle", 1'b0, 0, 1'b0, 1'b0);

        dly[0] = 5; dly[1] = 0; dly[2] = 12;
        run_seq(-1, 0, 1'b0);
        idle_cycles(3);

        run_seq(-1, 0, 1'b1);
        idle_cycles(2);

        dly[0] = 25; dly[1] = 3; dly[2] = 3;
        run_seq(-1, 0, 1'b1);
        idle_cycles(6);

        dly[0] = 3; dly[1] = 10; dly[2] = 4;
        run_seq(1, 4, 1'b0);
        idle_cycles(3);

        dly[0] = 7; dly[1] = 1; dly[2] = 19;
        run_seq(-1, 0, 1'b1);
        idle_cycles(2);

        for (int it = 0; it < 30; it++) begin
            int ap;
            for (int k = 0; k < NP; k++)
                dly[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MC, MC + 5))
                                                      : int'($urandom_range(0, MC - 1));
            ap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
            run_seq(ap, int'($urandom_range(0, 8)), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 4)));
        end

        // Reset pulled low between edges while the core is being started
        dly[0] = 4; dly[1] = 4; dly[2] = 4;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        exp_done = 1'b0;
        exp_to = 1'b0;
        check_all("pre_async", 1'b1, 0, 1'b1, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        exp_cout = 0;
        exp_ps = 0;
        check_all("async_rst", 1'b0, 0, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Run sequencer sitting above the single-cycle core.
- Launches NUM_PROGS programs back-to-back by pulsing the core's Start with the matching program select. It then waits for the core's Ack (halt) and measures each program's execution cycles.
- Reports the cycle count per program, enforces a watchdog timeout, and flags overall completion to the testbench or host.

Parameters:
- NUM_PROGS, 3: number of programs run per Go; ProgSel counts 0..NUM_PROGS-1.
- CW, 16: width of the cycle counter and of CycleOut.
- START_CYC, 2: number of cycles CpuStart is held high per launch (>=1).
- MAX_CYC, 16'hFFFF: watchdog limit in RUN cycles. Must be <= 2^CW - 1.

Ports:
- Clk  in  1  clock; posedge used.
- Reset  in  1  asynchronous, active-low; Reset==0 resets.
- Go  in  1  request to run all programs; sampled only in IDLE or DONE.
- Abort  in  1  synchronous abort of the current run.
- CpuAck  in  1  core halt flag (core's Ack).
- CpuStart  out  1  start/PC-init to core.
- ProgSel  out  max(1,$clog2(NUM_PROGS))  program index driven to core's fetch.
- Busy  out  1  high in LAUNCH, RUN, REPORT.
- CycleOut  out  CW  cycle count of the last finished program.
- CycleValid  out  1  one-cycle strobe; CycleOut valid.
- Done  out  1  sticky; all programs finished or run stopped by timeout.
- TimedOut  out  1  sticky; watchdog fired.

Behaviour:
- Registers, all outputs registered/Moore. Reset==0 forces:
  - state=IDLE
  - CpuStart=0, ProgSel=0, Busy=0, CycleOut=0, CycleValid=0, Done=0, TimedOut=0
  - internal CycleCt=0, StartCt=0
- States: IDLE, LAUNCH, RUN, REPORT, DONE.
- IDLE / DONE, Go=1:
  - next state LAUNCH; ProgSel<=0, Done<=0, TimedOut<=0, StartCt<=0.
  - Go=0 holds the current state.
- LAUNCH:
  - CpuStart=1 for exactly START_CYC consecutive cycles; ProgSel stable.
  - Then RUN with CycleCt=0.
  - CpuAck is ignored in LAUNCH.
- RUN (CpuStart=0), evaluated in priority order each cycle:
  - Abort: go to IDLE.
  - CpuAck=1: CycleOut<=CycleCt, then REPORT.
  - CycleCt==MAX_CYC-1: CycleOut<=MAX_CYC, TimedOut<=1, Done<=1, then DONE. CycleValid is not asserted; remaining programs are skipped.
  - Otherwise CycleCt<=CycleCt+1.
- Count definition: CycleOut = number of RUN cycles seen with CpuAck=0 before the first cycle with CpuAck=1. If CpuAck=1 in the first RUN cycle, CycleOut=0.
- REPORT:
  - CycleValid=1 for exactly one cycle.
  - If ProgSel==NUM_PROGS-1: Done<=1, then DONE, ProgSel holds.
  - Else ProgSel<=ProgSel+1, StartCt<=0, then LAUNCH.
- Abort:
  - Takes effect in any state except IDLE and DONE. Next state IDLE; CpuStart<=0, Busy<=0, ProgSel<=0.
  - No CycleValid is produced; Done and TimedOut are unchanged.
  - Abort in the same cycle as Go in IDLE: Abort wins, stay IDLE.
- Go while Busy is ignored; it is not queued.
- Busy=1 exactly while in LAUNCH, RUN or REPORT.
- Reset asserted mid-run: immediate return to reset values. CpuStart drops asynchronously.
- Counter never wraps: the watchdog fires before CycleCt overflows CW.

Test Plan:
- Reset: Reset=0 for 3 cycles, then release. Required: every output 0, state IDLE; Go=0 for 10 cycles keeps Busy=0.
- Normal run, NUM_PROGS=3, START_CYC=2: Go pulse; core model raises CpuAck after 5, 0 and 12 RUN cycles.
  - CpuStart high for 2 cycles before each run; ProgSel 0, 1, 2.
  - CycleValid strobes with CycleOut=5, 0, 12.
  - Then Done=1, Busy=0, TimedOut=0.
- Watchdog, MAX_CYC=20: CpuAck never asserted.
  - After 20 RUN cycles: TimedOut=1, Done=1, CycleOut=20, no CycleValid.
  - ProgSel stays 0; programs 1 and 2 are never launched.
- Abort mid-RUN of program 1, after 4 RUN cycles:
  - Next cycle IDLE, ProgSel=0, Busy=0, no CycleValid for program 1, Done=0.
  - A following Go restarts at ProgSel=0.
- Go ignored while Busy: Go pulses during LAUNCH and RUN have no effect on the sequence.
  - Go in DONE clears Done and TimedOut and reruns from ProgSel=0.
- Async reset during LAUNCH (CpuStart=1): Reset=0 between clock edges.
  - CpuStart drops to 0 before the next posedge; state IDLE after release.
